// File: rtl/psum_acc_buffer.sv
// psum_acc_buffer: partial-sum store with overwrite / lane-wise accumulate
// writes, a one-stage read-modify-write pipeline with same-address forwarding,
// a bulk-clear FSM and a registered read port.
// Optional feature macro: PSUM_SAT_EN (per-lane saturating accumulate plus
// sticky sat_flag). When it is undefined, lanes wrap and sat_flag is tied 0.
module psum_acc_buffer #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 2048,
  parameter int addr_w  = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [addr_w-1:0]        wr_addr,
  input  logic [col*psum_bw-1:0]   wr_data,
  input  logic                     acc,
  input  logic                     rd_en,
  input  logic [addr_w-1:0]        rd_addr,
  output logic [col*psum_bw-1:0]   rd_data,
  output logic                     rd_valid,
  input  logic                     clr,
  output logic                     busy,
  output logic                     sat_flag
);

  localparam int                W         = col * psum_bw;
  localparam logic [addr_w:0]   DEPTH_L   = (addr_w + 1)'(depth);
  localparam logic [addr_w-1:0] LAST_ADDR = addr_w'(depth - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t            state, next_state;
  logic [addr_w-1:0] clr_cnt, next_cnt;

  logic [W-1:0] mem [depth];

  logic              s1_valid;
  logic [addr_w-1:0] s1_addr;
  logic [W-1:0]      s1_data;
  logic              s1_acc;
  logic [W-1:0]      s1_old;

  logic              wr_accept;
  logic              rd_accept;
  logic              clr_start;
  logic              commit;
  logic              fwd_hit;
  logic              rd_hit;
  logic [W-1:0]      commit_data;
  logic [W-1:0]      old_next;
  logic [W-1:0]      rd_word;
  logic [psum_bw-1:0] old_lane;
  logic [psum_bw-1:0] data_lane;
`ifdef PSUM_SAT_EN
  logic [psum_bw:0]  lane_sum;
  logic              commit_sat;
`endif

  // Addresses at or above depth are outside the store.
  function automatic logic in_range(input logic [addr_w-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  // FSM state and clear-counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= next_state;
      clr_cnt <= next_cnt;
    end
  end

  // FSM next state, clear counter progression and handshake outputs.
  always_comb begin
    next_state = state;
    next_cnt   = clr_cnt;
    wr_ready   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        if (clr) begin
          next_state = CLEAR;
          next_cnt   = '0;
        end
      end
      CLEAR: begin
        busy = 1'b1;
        if (clr_cnt == LAST_ADDR) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else begin
          next_cnt = clr_cnt + addr_w'(1);
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // Handshake qualifiers, forwarding hits and the old-value / read-data muxes.
  always_comb begin
    wr_accept = wr_valid && (state == IDLE);
    rd_accept = rd_en && (state == IDLE);
    clr_start = clr && (state == IDLE);
    commit    = s1_valid && in_range(s1_addr);
    fwd_hit   = commit && (s1_addr == wr_addr);
    rd_hit    = commit && (s1_addr == rd_addr);
    old_next  = '0;
    rd_word   = '0;
    if (fwd_hit)
      old_next = commit_data;
    else if (in_range(wr_addr))
      old_next = mem[wr_addr];
    if (rd_hit)
      rd_word = commit_data;
    else if (in_range(rd_addr))
      rd_word = mem[rd_addr];
  end

  // Value committed by the s1 stage: overwrite data or lane-wise sum.
  always_comb begin
    commit_data = s1_data;
    old_lane    = '0;
    data_lane   = '0;
`ifdef PSUM_SAT_EN
    lane_sum    = '0;
    commit_sat  = 1'b0;
`endif
    if (s1_acc) begin
      for (int unsigned i = 0; i < col; i++) begin
        old_lane  = s1_old[i*psum_bw +: psum_bw];
        data_lane = s1_data[i*psum_bw +: psum_bw];
`ifdef PSUM_SAT_EN
        lane_sum = {old_lane[psum_bw-1], old_lane} + {data_lane[psum_bw-1], data_lane};
        if (lane_sum[psum_bw] != lane_sum[psum_bw-1]) begin
          commit_sat = 1'b1;
          commit_data[i*psum_bw +: psum_bw] = lane_sum[psum_bw] ?
            {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
        end else begin
          commit_data[i*psum_bw +: psum_bw] = lane_sum[psum_bw-1:0];
        end
`else
        commit_data[i*psum_bw +: psum_bw] = old_lane + data_lane;
`endif
      end
    end
  end

  // s1 pipeline stage: capture the accepted write together with its old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= wr_accept;
      if (wr_accept) begin
        s1_addr <= wr_addr;
        s1_data <= wr_data;
        s1_acc  <= acc;
        s1_old  <= old_next;
      end
    end
  end

  // Storage array: s1 commit, then the clear write so clear wins on a collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (commit)
        mem[s1_addr] <= commit_data;
      if (state == CLEAR)
        mem[clr_cnt] <= '0;
    end
  end

  // Registered read port with write-first forwarding of the committing write.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept)
        rd_data <= rd_word;
    end
  end

`ifdef PSUM_SAT_EN
  // Sticky saturation flag; a starting clear wipes the array, so it wins.
  always_ff @(posedge clk) begin
    if (reset)
      sat_flag <= 1'b0;
    else if (clr_start)
      sat_flag <= 1'b0;
    else if (commit && commit_sat)
      sat_flag <= 1'b1;
  end
`else
  assign sat_flag = 1'b0;
`endif

endmodule
